// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. A single full-adder cell walks a
// WIDTH-bit operand pair LSB first, one bit per clock, then registers sum and carry.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shifted;
    logic [CW-1:0]    bit_cnt;
    logic             carry_q;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    // The one shared full-adder cell; sum bits enter at the MSB so that after
    // WIDTH shifts bit 0 of the result has reached bit 0 of the register.
    always_comb begin
        {fa_c, fa_s} = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry_q};
        sum_shifted  = {fa_s, sum_sh[WIDTH-1:1]};
        last_bit     = (bit_cnt == LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_out = (state != IDLE);
        done_out = (state == DONE);
    end

    // Operands are copied on the accepted start so the requester may change
    // them freely; result registers move only on the completing bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_q   <= 1'b0;
            bit_cnt   <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        carry_q <= carry_in;
                        bit_cnt <= '0;
                    end
                end
                ADD: begin
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    sum_sh  <= sum_shifted;
                    carry_q <= fa_c;
                    if (last_bit) begin
                        sum_out   <= sum_shifted;
                        carry_out <= fa_c;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench running directed and random adds on
// WIDTH=2, 8 and 32 instances against an a+b+cin reference model.
module tb_serial_add_ctrl;

    typedef struct {
        logic [32:0] res;
        int          done_cyc;
    } exp_t;

    localparam int RAND_OPS    = 1000;
    localparam int CYCLE_LIMIT = 90000;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int W       = (gi == 0) ? 2 : (gi == 1) ? 8 : 32;
        localparam int RST_CYC = (W > 4) ? 4 : 1;

        logic         rst;
        logic         start_in;
        logic         carry_in;
        logic         busy_out;
        logic         done_out;
        logic         carry_out;
        logic [W-1:0] a_in;
        logic [W-1:0] b_in;
        logic [W-1:0] sum_out;
        logic [W-1:0] msb_only;
        logic         rst_q = 1'b0;
        bit           mon_en = 1'b0;
        bit           fin = 1'b0;
        int           next_accept = 0;
        exp_t         exp_q[$];
        logic [32:0]  last_res = '0;

        serial_add_ctrl #(.WIDTH(W)) dut (
            .clk       (clk),
            .rst       (rst),
            .start_in  (start_in),
            .a_in      (a_in),
            .b_in      (b_in),
            .carry_in  (carry_in),
            .busy_out  (busy_out),
            .done_out  (done_out),
            .sum_out   (sum_out),
            .carry_out (carry_out)
        );

        always @(posedge clk) rst_q <= rst;

        task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] req);
            checks++;
            if (act !== req) begin
                failures++;
                $display("[TB] FAIL W=%0d %s cycle=%0d actual=%0h required=%0h", W, name, cyc, act, req);
            end
        endtask

        // Monitor: the model knows when each accepted add must complete; it pops
        // the expected result at that cycle and checks every output every cycle.
        always @(negedge clk) begin
            bit   exp_busy;
            bit   exp_done;
            exp_t e;
            if (rst_q === 1'b1) mon_en = 1'b1;
            if (mon_en) begin
                if (rst_q) begin
                    exp_q.delete();
                    last_res = '0;
                end
                exp_busy = 1'b0;
                exp_done = 1'b0;
                if (exp_q.size() > 0) begin
                    if (cyc >= exp_q[0].done_cyc - W) exp_busy = 1'b1;
                    if (cyc == exp_q[0].done_cyc) begin
                        exp_done = 1'b1;
                        e = exp_q.pop_front();
                        last_res = e.res;
                    end
                end
                checkOutput("busy_out", 33'(busy_out), 33'(exp_busy));
                checkOutput("done_out", 33'(done_out), 33'(exp_done));
                checkOutput("carry_sum", 33'({carry_out, sum_out}), last_res);
            end
        end

        task automatic stepCycle();
            @(posedge clk);
            #1;
        endtask

        task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
            exp_t e;
            start_in = 1'b0;
            while (cyc + 1 < next_accept) stepCycle();
            start_in = 1'b1;
            a_in     = a;
            b_in     = b;
            carry_in = cin;
            e.res      = 33'(a) + 33'(b) + 33'(cin);
            e.done_cyc = cyc + 1 + W;
            exp_q.push_back(e);
            next_accept = cyc + 1 + W + 2;
            stepCycle();
            start_in = 1'b0;
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            carry_in = 1'($urandom);
        endtask

        // Busy period: operands churn every cycle and stray starts are issued.
        task automatic waitIdle(input int noise_pct);
            while (cyc + 1 < next_accept) begin
                start_in = (int'($urandom_range(0, 99)) < noise_pct);
                a_in     = W'($urandom);
                b_in     = W'($urandom);
                carry_in = 1'($urandom);
                stepCycle();
            end
            start_in = 1'b0;
        endtask

        task automatic resetDut(input int cycles);
            rst = 1'b1;
            for (int i = 0; i < cycles; i++) begin
                start_in = 1'($urandom);
                a_in     = W'($urandom);
                b_in     = W'($urandom);
                carry_in = 1'($urandom);
                stepCycle();
            end
            rst      = 1'b0;
            start_in = 1'b0;
            stepCycle();
            next_accept = cyc + 1;
        endtask

        initial begin
            msb_only        = '0;
            msb_only[W-1]   = 1'b1;
            resetDut(2);

            applyStimulus(W'(8'h5A), W'(8'h3C), 1'b0);
            waitIdle(0);
            applyStimulus('1, W'(1), 1'b0);
            waitIdle(0);
            applyStimulus('1, '1, 1'b1);
            waitIdle(0);
            applyStimulus(W'(8'h10), W'(8'h01), 1'b0);
            waitIdle(100);

            applyStimulus(W'(8'h33), W'(8'h44), 1'b1);
            for (int i = 1; i < RST_CYC; i++) stepCycle();
            rst = 1'b1;
            stepCycle();
            rst = 1'b0;
            stepCycle();
            next_accept = cyc + 1;

            applyStimulus(W'(8'h01), W'(8'h02), 1'b1);
            waitIdle(0);
            applyStimulus(msb_only, msb_only, 1'b0);
            waitIdle(0);
            applyStimulus(msb_only, msb_only, 1'b0);
            waitIdle(0);

            for (int i = 0; i < RAND_OPS; i++) begin
                repeat ($urandom_range(0, 3)) stepCycle();
                applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
                waitIdle(int'($urandom_range(0, 1)) * 30);
            end
            repeat (3) stepCycle();
            checkOutput("drained", 33'(exp_q.size()), 33'(0));
            fin = 1'b1;
        end
    end

    initial begin
        while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && cyc < CYCLE_LIMIT) @(posedge clk);
        if (!(g_w[0].fin && g_w[1].fin && g_w[2].fin)) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout cycle=%0d actual=unfinished required=finished", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
